// File: rtl/count_seq_checker.sv
// Sequence checker for the LO..HI modulo counter: tracks lock, flags sequence errors,
// and keeps wrap/error statistics.
//
// state   | meaning
// IDLE    | no reference sample yet; next in-range sample becomes prev
// ACQUIRE | counting consecutive correct transitions toward LOCK_N
// LOCKED  | sequence confirmed; mismatches are reported as errors
module count_seq_checker #(
    parameter logic [3:0]  LO     = 4'd3,
    parameter logic [3:0]  HI     = 4'd12,
    parameter int unsigned LOCK_N = 4,
    parameter int unsigned WRAP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        count_in,
    input  logic              count_valid,
    input  logic              clear,
    output logic              locked,
    output logic              seq_err,
    output logic              err_sticky,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic [7:0]        err_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [3:0] LP_LOCK_N = 4'(LOCK_N);

    state_t            r_state, w_next_state;
    logic [3:0]        r_prev, w_next_prev;
    logic [3:0]        r_good_cnt, w_next_good;
    logic              r_locked, r_seq_err, r_err_sticky, r_wrap_pulse;
    logic [WRAP_W-1:0] r_wrap_count;
    logic [7:0]        r_err_count;

    logic       w_in_range;
    logic [3:0] w_exp;
    logic       w_match;
    logic [3:0] w_good_inc;
    logic       w_err;
    logic       w_wrap;

    assign w_in_range = (count_in >= LO) && (count_in <= HI);
    assign w_exp      = (r_prev == HI) ? LO : r_prev + 4'd1;
    assign w_match    = (count_in == w_exp);
    assign w_good_inc = r_good_cnt + 4'd1;

    always_comb begin
        w_next_state = r_state;
        w_next_prev  = r_prev;
        w_next_good  = r_good_cnt;
        w_err        = 1'b0;
        w_wrap       = 1'b0;
        if (count_valid) begin
            if (!w_in_range) begin
                // prev deliberately kept: an out-of-range value is never a reference
                w_err        = 1'b1;
                w_next_state = IDLE;
                w_next_good  = 4'd0;
            end else begin
                w_next_prev = count_in;
                unique case (r_state)
                    IDLE: begin
                        w_next_good  = 4'd0;
                        w_next_state = ACQUIRE;
                    end
                    ACQUIRE: begin
                        if (w_match) begin
                            w_next_good = w_good_inc;
                            if (w_good_inc == LP_LOCK_N) begin
                                w_next_state = LOCKED;
                            end
                        end else begin
                            w_next_good = 4'd0;
                        end
                    end
                    LOCKED: begin
                        if (w_match) begin
                            w_wrap = (r_prev == HI);
                        end else begin
                            w_err        = 1'b1;
                            w_next_good  = 4'd0;
                            w_next_state = ACQUIRE;
                        end
                    end
                    default: begin
                        w_next_good  = 4'd0;
                        w_next_state = IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_prev     <= 4'd0;
            r_good_cnt <= 4'd0;
            r_locked   <= 1'b0;
            r_seq_err  <= 1'b0;
            r_wrap_pulse <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_prev       <= w_next_prev;
            r_good_cnt   <= w_next_good;
            r_locked     <= (w_next_state == LOCKED);
            r_seq_err    <= w_err;
            r_wrap_pulse <= w_wrap;
        end
    end

    // clear wins over a same-cycle increment; the pulses above are unaffected
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_sticky <= 1'b0;
            r_err_count  <= 8'd0;
            r_wrap_count <= '0;
        end else if (clear) begin
            r_err_sticky <= 1'b0;
            r_err_count  <= 8'd0;
            r_wrap_count <= '0;
        end else begin
            if (w_err) begin
                r_err_sticky <= 1'b1;
                if (r_err_count != 8'hFF) begin
                    r_err_count <= r_err_count + 8'd1;
                end
            end
            if (w_wrap) begin
                r_wrap_count <= r_wrap_count + 1'b1;
            end
        end
    end

    assign locked     = r_locked;
    assign seq_err    = r_seq_err;
    assign err_sticky = r_err_sticky;
    assign wrap_pulse = r_wrap_pulse;
    assign wrap_count = r_wrap_count;
    assign err_count  = r_err_count;

endmodule

// File: tb/tb_count_seq_checker.sv
// Scoreboard bench for count_seq_checker: directed samples push hand-computed
// expectations; a monitor checks them one cycle after each sampling edge.
module tb_count_seq_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] count_in;
    logic       count_valid;
    logic       clear;
    logic       locked, seq_err, err_sticky, wrap_pulse;
    logic [7:0] wrap_count;
    logic [7:0] err_count;

    typedef struct {
        logic       l;
        logic       s;
        logic       w;
        logic       st;
        logic [7:0] ec;
        logic [7:0] wc;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    count_seq_checker dut (
        .clk        (clk),
        .reset      (reset),
        .count_in   (count_in),
        .count_valid(count_valid),
        .clear      (clear),
        .locked     (locked),
        .seq_err    (seq_err),
        .err_sticky (err_sticky),
        .wrap_pulse (wrap_pulse),
        .wrap_count (wrap_count),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk({e.tag, ".locked"},     int'(locked),     int'(e.l));
            chk({e.tag, ".seq_err"},    int'(seq_err),    int'(e.s));
            chk({e.tag, ".wrap_pulse"}, int'(wrap_pulse), int'(e.w));
            chk({e.tag, ".err_sticky"}, int'(err_sticky), int'(e.st));
            chk({e.tag, ".err_count"},  int'(err_count),  int'(e.ec));
            chk({e.tag, ".wrap_count"}, int'(wrap_count), int'(e.wc));
        end
    end

    task automatic drv(input string tag, input logic v, input logic [3:0] c, input logic clr,
                       input logic el, input logic es, input logic ew, input logic est,
                       input int ec, input int wc);
        exp_t e;
        @(negedge clk);
        count_valid = v;
        count_in    = c;
        clear       = clr;
        e.l = el; e.s = es; e.w = ew; e.st = est;
        e.ec = 8'(ec); e.wc = 8'(wc); e.tag = tag;
        q.push_back(e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; count_in = 4'd0; count_valid = 1'b0; clear = 1'b0;
        #1;
        chk("reset.locked", int'(locked), 0);
        chk("reset.err_count", int'(err_count), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // acquire: lock on the 4th correct successor (sample 7)
        drv("acq3", 1, 3, 0, 0, 0, 0, 0, 0, 0);
        drv("acq4", 1, 4, 0, 0, 0, 0, 0, 0, 0);
        drv("acq5", 1, 5, 0, 0, 0, 0, 0, 0, 0);
        drv("acq6", 1, 6, 0, 0, 0, 0, 0, 0, 0);
        drv("acq7", 1, 7, 0, 1, 0, 0, 0, 0, 0);
        // locked wrap
        for (int v = 8; v <= 12; v++) drv("run", 1, 4'(v), 0, 1, 0, 0, 0, 0, 0);
        drv("wrap3", 1, 3, 0, 1, 0, 1, 0, 0, 1);
        drv("wrap4", 1, 4, 0, 1, 0, 0, 0, 0, 1);
        // locked mismatch 8 -> 10, then relock; 12->3 in ACQUIRE is no wrap
        for (int v = 5; v <= 8; v++) drv("pre", 1, 4'(v), 0, 1, 0, 0, 0, 0, 1);
        drv("skip10", 1, 10, 0, 0, 1, 0, 1, 1, 1);
        drv("re11",   1, 11, 0, 0, 0, 0, 1, 1, 1);
        drv("re12",   1, 12, 0, 0, 0, 0, 1, 1, 1);
        drv("re3",    1, 3,  0, 0, 0, 0, 1, 1, 1);
        drv("re4",    1, 4,  0, 1, 0, 0, 1, 1, 1);
        // valid gaps are ignored
        drv("gap1",   0, 9,  0, 1, 0, 0, 1, 1, 1);
        drv("gap5",   1, 5,  0, 1, 0, 0, 1, 1, 1);
        drv("gap2",   0, 2,  0, 1, 0, 0, 1, 1, 1);
        drv("gap6",   1, 6,  0, 1, 0, 0, 1, 1, 1);
        // out of range -> IDLE, relock on 9
        drv("oor14",  1, 14, 0, 0, 1, 0, 1, 2, 1);
        drv("id5",    1, 5,  0, 0, 0, 0, 1, 2, 1);
        drv("id6",    1, 6,  0, 0, 0, 0, 1, 2, 1);
        drv("id7",    1, 7,  0, 0, 0, 0, 1, 2, 1);
        drv("id8",    1, 8,  0, 0, 0, 0, 1, 2, 1);
        drv("id9",    1, 9,  0, 1, 0, 0, 1, 2, 1);
        // clear with a same-cycle locked mismatch
        drv("clrerr", 1, 11, 1, 0, 1, 0, 0, 0, 0);
        drv("c12",    1, 12, 0, 0, 0, 0, 0, 0, 0);
        drv("c3",     1, 3,  0, 0, 0, 0, 0, 0, 0);
        drv("c4",     1, 4,  0, 0, 0, 0, 0, 0, 0);
        drv("c5",     1, 5,  0, 1, 0, 0, 0, 0, 0);
        for (int v = 6; v <= 12; v++) drv("crun", 1, 4'(v), 0, 1, 0, 0, 0, 0, 0);
        // clear with a same-cycle wrap: pulse emitted, count not kept
        drv("clrwrap", 1, 3, 1, 1, 0, 1, 0, 0, 0);
        drv("cw4",     1, 4, 0, 1, 0, 0, 0, 0, 0);
        drv("rep4",    1, 4, 0, 0, 1, 0, 1, 1, 0);
        // 300 errors using the just-out-of-range values 2 and 13
        for (int i = 0; i < 300; i++)
            drv("sat", 1, (i % 2 == 0) ? 4'd2 : 4'd13, 0, 0, 1, 0, 1, (i + 2 > 255) ? 255 : i + 2, 0);
        drv("hi12", 1, 12, 0, 0, 0, 0, 1, 255, 0);
        drv("l3",   1, 3,  0, 0, 0, 0, 1, 255, 0);
        drv("l4",   1, 4,  0, 0, 0, 0, 1, 255, 0);
        drv("l5",   1, 5,  0, 0, 0, 0, 1, 255, 0);
        drv("l6",   1, 6,  0, 1, 0, 0, 1, 255, 0);
        @(negedge clk);
        count_valid = 1'b0;
        // async reset between edges while locked
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("arst.locked",     int'(locked),     0);
        chk("arst.err_sticky", int'(err_sticky), 0);
        chk("arst.err_count",  int'(err_count),  0);
        chk("arst.seq_err",    int'(seq_err),    0);
        chk("arst.wrap_pulse", int'(wrap_pulse), 0);
        @(negedge clk);
        reset = 1'b1;
        drv("pr7",  1, 7,  0, 0, 0, 0, 0, 0, 0);
        drv("pr8",  1, 8,  0, 0, 0, 0, 0, 0, 0);
        drv("pr9",  1, 9,  0, 0, 0, 0, 0, 0, 0);
        drv("pr10", 1, 10, 0, 0, 0, 0, 0, 0, 0);
        drv("pr11", 1, 11, 0, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        count_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/count_seq_checker.md
# count_seq_checker

Downstream monitor for the 3-to-12 synchronous counter. It samples the counter's 4-bit output on every valid cycle and checks that the value follows the modulo sequence 3→4→…→12→3. It acquires lock after a run of correct transitions and reports sequence errors and wrap events. It also keeps wrap and error statistics for the system status logic.

## Interface
- LO, 4'd3: lowest legal count value; the value that follows HI.
- HI, 4'd12: highest legal count value. Requires LO < HI.
- LOCK_N, 4: number of consecutive correct transitions needed to lock. Legal range 1–15.
- WRAP_W, 8: width of wrap_count.
- clk  input  1  rising-edge clock; the same clock as the counter.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- count_in  input  4  counter value under check.
- count_valid  input  1  count_in is sampled only on cycles where this is 1.
- clear  input  1  synchronous clear of the statistics: err_sticky, err_count, wrap_count.
- locked  output  1  1 while the FSM is in LOCKED.
- seq_err  output  1  one-cycle pulse when a sequence error is detected.
- err_sticky  output  1  set by seq_err; cleared only by reset or clear.
- wrap_pulse  output  1  one-cycle pulse on a HI→LO transition while locked.
- wrap_count  output  WRAP_W  number of locked wraps, modulo 2^WRAP_W.
- err_count  output  8  number of seq_err pulses; saturates at 255.

## Operation
- Internal state:
  - prev[3:0]: last accepted sample.
  - good_cnt[3:0]: consecutive correct transitions.
  - FSM with states IDLE, ACQUIRE, LOCKED.
- Expected next value: exp = (prev == HI) ? LO : prev + 1.
- In-range means LO ≤ count_in ≤ HI.
- count_valid = 0: all state holds; seq_err and wrap_pulse are 0.
- Out-of-range valid sample, in any state:
  - seq_err pulses and err_count increments.
  - Next state is IDLE and good_cnt is 0.
  - prev is not updated.
- IDLE, in-range sample: prev ← count_in, good_cnt ← 0, next state ACQUIRE.
- ACQUIRE, in-range sample:
  - count_in == exp: good_cnt increments. When the incremented value equals LOCK_N, next state is LOCKED.
  - Mismatch: good_cnt ← 0, stay in ACQUIRE, no seq_err (silent resync).
  - prev ← count_in in both cases.
- LOCKED, in-range sample:
  - count_in == exp: stay in LOCKED. If prev == HI, wrap_pulse is 1 and wrap_count increments.
  - Mismatch: seq_err, err_sticky set, err_count increments, good_cnt ← 0, next state ACQUIRE.
  - prev ← count_in in both cases.
- Repeated values, e.g. 5→5, count as a mismatch.
- clear:
  - Zeroes err_sticky, err_count and wrap_count on the next edge.
  - Takes priority over a same-cycle increment or set, so that event is not counted.
  - The same-cycle seq_err and wrap_pulse pulses are still emitted.
  - Has no effect on the FSM, prev or good_cnt.
- err_count holds at 255; wrap_count wraps from 2^WRAP_W−1 to 0.

## Timing
- All outputs are registered. A sample presented before rising edge k produces its response (seq_err, wrap_pulse, locked, counters) visible from edge k until edge k+1. Latency is 1 cycle.
- Pulse outputs are high for exactly one cycle per event. Back-to-back events give back-to-back pulses.
- Reset asserted (reset = 0): immediately and asynchronously, every output is 0, FSM = IDLE, prev = 0, good_cnt = 0.
- Reset mid-stream discards lock and statistics. After release, the first valid sample is treated as in IDLE.
- Reset release is synchronised externally; the block needs no extra release handling.
- Minimum lock time from IDLE, with continuous valid correct samples: 1 + LOCK_N samples. locked rises on the edge that samples the LOCK_N-th correct successor.

## Test plan
- Reset, then feed 3,4,5,6,7 with valid = 1 → locked = 0 through sample 6; locked = 1 after the edge sampling 7; seq_err never asserted.
- While locked, feed …,11,12,3,4 → wrap_pulse high only for the cycle after sampling 3; wrap_count = 1; locked stays 1.
- While locked, feed 8 then 10 → seq_err one cycle, err_sticky = 1, err_count = 1, locked = 0. Then 11,12,3,4 → locked = 1 again, no wrap_pulse for the 12→3 seen during ACQUIRE.
- Feed 14 in any state → seq_err, FSM = IDLE, locked = 0. Then 5,6,7,8,9 → relock on 9.
- Drive clear in the same cycle as a locked mismatch → seq_err pulses; err_count = 0 and err_sticky = 0 afterwards. Force 300 errors → err_count = 255.
- Assert reset low mid-sequence while locked, between clock edges → all outputs 0 immediately. Toggle count_valid = 0 between correct samples → the gaps are ignored and the lock is held.
